// File: rtl/lbp_engine_p.sv
// Local-binary-pattern engine: streams a gray frame in raster order, keeps a 3x3
// window in a 2-line shift buffer and writes one LBP code per output address.
module lbp_engine_p #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int PIX_W       = 8,
    parameter int AW          = 6,
    parameter int BORDER_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PIX_W-1:0] thr,
    output logic             gray_req,
    output logic [AW-1:0]    gray_addr,
    input  logic [PIX_W-1:0] gray_data,
    output logic [AW-1:0]    lbp_addr,
    output logic [7:0]       lbp_data,
    output logic             lbp_write,
    output logic             busy,
    output logic             finish
);

    localparam int          NPIX = IMG_W * IMG_H;
    localparam int          CW   = AW + 2;
    localparam int unsigned SRL  = 2 * IMG_W + 3;

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_MAX  = CW'(IMG_H - 1);
    localparam logic [CW-1:0] LAST_WR  = (BORDER_MODE != 0) ? CW'(NPIX - 1) : CW'(NPIX - IMG_W - 2);
    localparam logic [CW-1:0] FIRST_WR = (BORDER_MODE != 0) ? '0 : CW'(IMG_W + 1);
    localparam logic [CW-1:0] FIRST_RC = (BORDER_MODE != 0) ? '0 : CW'(1);
    localparam logic [CW-1:0] WIN_LAG  = CW'(IMG_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WSET,
        S_WPUL,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [PIX_W-1:0]  r_thr;
    logic [CW-1:0]     r_ncap;
    logic [CW-1:0]     r_wptr;
    logic [CW-1:0]     r_wrow;
    logic [CW-1:0]     r_wcol;
    logic [AW-1:0]     r_lbp_addr;
    logic [7:0]        r_lbp_data;
    logic [PIX_W-1:0]  r_sr [SRL];

    logic              w_cap;
    logic              w_accept;
    logic [CW-1:0]     w_ncap;
    logic [CW-1:0]     w_wptr;
    logic [CW-1:0]     w_wrow;
    logic [CW-1:0]     w_wcol;
    logic              w_border;
    logic              w_rdy;
    logic [7:0]        w_code;
    logic [PIX_W-1:0]  w_sr [SRL];
    logic [PIX_W-1:0]  w_nb [8];
    logic [PIX_W:0]    w_ref;

    // Window taps: w_sr[0] is the newest pixel, the center sits IMG_W+1 behind it.
    always_comb begin
        w_cap    = (r_state == S_READ);
        w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_ncap   = w_cap ? r_ncap + CW'(1) : r_ncap;
        w_sr[0]  = w_cap ? gray_data : r_sr[0];
        for (int unsigned i = 1; i < SRL; i++) begin
            w_sr[i] = w_cap ? r_sr[i-1] : r_sr[i];
        end
        w_nb[0] = w_sr[2*IMG_W+2];
        w_nb[1] = w_sr[2*IMG_W+1];
        w_nb[2] = w_sr[2*IMG_W];
        w_nb[3] = w_sr[IMG_W+2];
        w_nb[4] = w_sr[IMG_W];
        w_nb[5] = w_sr[2];
        w_nb[6] = w_sr[1];
        w_nb[7] = w_sr[0];
        w_ref   = {1'b0, w_sr[IMG_W+1]} + {1'b0, r_thr};
    end

    // Write pointer walks every address (border mode) or only interior ones.
    always_comb begin
        w_wptr = r_wptr;
        w_wrow = r_wrow;
        w_wcol = r_wcol;
        if (r_state == S_WPUL) begin
            if (BORDER_MODE != 0) begin
                w_wptr = r_wptr + CW'(1);
                if (r_wcol == COL_MAX) begin
                    w_wcol = '0;
                    w_wrow = r_wrow + CW'(1);
                end else begin
                    w_wcol = r_wcol + CW'(1);
                end
            end else if (r_wcol == COL_MAX - CW'(1)) begin
                w_wptr = r_wptr + CW'(3);
                w_wcol = CW'(1);
                w_wrow = r_wrow + CW'(1);
            end else begin
                w_wptr = r_wptr + CW'(1);
                w_wcol = r_wcol + CW'(1);
            end
        end
        w_border = (w_wrow == '0) || (w_wrow == ROW_MAX) || (w_wcol == '0) || (w_wcol == COL_MAX);
        if (w_border) begin
            w_rdy = (BORDER_MODE != 0) && (w_wptr < w_ncap);
        end else begin
            w_rdy = (w_wptr + WIN_LAG) < w_ncap;
        end
        w_code = '0;
        if (!w_border) begin
            for (int unsigned k = 0; k < 8; k++) begin
                w_code[k] = ({1'b0, w_nb[k]} >= w_ref);
            end
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_nxt = S_READ;
            S_READ:         if (w_rdy) w_nxt = S_WSET;
            S_WSET:         w_nxt = S_WPUL;
            S_WPUL: begin
                if (r_wptr == LAST_WR) w_nxt = S_DONE;
                else if (w_rdy)        w_nxt = S_WSET;
                else                   w_nxt = S_READ;
            end
            default:        w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_thr      <= '0;
            r_ncap     <= '0;
            r_wptr     <= '0;
            r_wrow     <= '0;
            r_wcol     <= '0;
            r_lbp_addr <= '0;
            r_lbp_data <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_accept) begin
                r_thr  <= thr;
                r_ncap <= '0;
                r_wptr <= FIRST_WR;
                r_wrow <= FIRST_RC;
                r_wcol <= FIRST_RC;
            end else begin
                r_ncap <= w_ncap;
                r_wptr <= w_wptr;
                r_wrow <= w_wrow;
                r_wcol <= w_wcol;
            end
            if ((w_nxt == S_WSET) && (r_state != S_WSET)) begin
                r_lbp_addr <= w_wptr[AW-1:0];
                r_lbp_data <= w_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < SRL; i++) begin
            r_sr[i] <= w_sr[i];
        end
    end

    assign gray_req  = (r_state == S_READ);
    assign gray_addr = r_ncap[AW-1:0];
    assign lbp_addr  = r_lbp_addr;
    assign lbp_data  = r_lbp_data;
    assign lbp_write = (r_state == S_WPUL);
    assign busy      = (r_state == S_READ) || (r_state == S_WSET) || (r_state == S_WPUL);
    assign finish    = (r_state == S_DONE);

endmodule
